// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: access-size codes,
// requester indices, the command-stage record and the request error check.
package dmem_pkg;

    // Access-size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Requester indices into the per-port vectors
    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    // Command-stage record. The byte address is kept beside this record in
    // the top level because its width follows the AW parameter.
    typedef struct packed {
        logic        owner;   // port that issued the command
        logic        we;      // 1 = store, 0 = load
        logic [1:0]  size;    // SZ_* code
        logic        sgn;     // sign-extend subword loads
        logic        err;     // misaligned or illegal size
        logic [31:0] wdata;   // store data, subword data in the low bits
    } dmem_cmd_t;

    // A request is in error when its size is illegal or its address is not
    // naturally aligned for that size.
    function automatic logic size_err(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte or halfword out of a memory word and zero- or
// sign-extends it to 32 bits; whole-word loads pass straight through.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lasttwo_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_bytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = word_i[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane_bytes[lasttwo_i];
    assign half_sel = lasttwo_i[1] ? word_i[31:16] : word_i[15:0];

    // Extend the selected lane according to size and signedness
    always_comb begin
        data_o = 32'h0;
        case (size_i)
            SZ_BYTE: data_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{sgn_i & half_sel[15]}}, half_sel};
            SZ_WORD: data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-ported word memory. One request is
// accepted per cycle, registered into a command stage that drives the memory
// controls directly, and answered two cycles after acceptance.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int   AW    = 7,
    parameter logic RR_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [3:0]          req_size,
    input  logic [1:0]          req_signed,
    input  logic [2*(AW+2)-1:0] req_addr,
    input  logic [63:0]         req_wdata,
    output logic [1:0]          rsp_valid,
    output logic                rsp_err,
    output logic [31:0]         rsp_rdata,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_we,
    output logic                mem_re,
    output logic                mem_special,
    output logic                mem_borh,
    output logic [1:0]          mem_lasttwo,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    // Per-port views of the flattened request buses
    logic [AW+1:0] addr_arr  [2];
    logic [1:0]    size_arr  [2];
    logic [31:0]   wdata_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign addr_arr[gi]  = req_addr[gi*(AW+2) +: (AW+2)];
            assign size_arr[gi]  = req_size[gi*2 +: 2];
            assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
        end
    endgenerate

    logic [1:0]    grant;
    logic          accept;
    logic          sel;
    logic          last_grant_q, last_grant_d;
    logic          cmd_valid_q, cmd_valid_d;
    dmem_cmd_t     cmd_q, cmd_d;
    logic [AW+1:0] cmd_addr_q, cmd_addr_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [31:0]   load_data;
    logic          issue_ok;

    // Pick one requester: alternate on a tie in round-robin mode, otherwise
    // let the CPU port win
    always_comb begin
        grant = 2'b00;
        if (RR_EN) begin
            if (req_valid == 2'b11) begin
                if (last_grant_q) grant[PORT_CPU] = 1'b1;
                else              grant[PORT_DBG] = 1'b1;
            end else begin
                grant = req_valid;
            end
        end else begin
            if (req_valid[PORT_CPU])      grant[PORT_CPU] = 1'b1;
            else if (req_valid[PORT_DBG]) grant[PORT_DBG] = 1'b1;
        end
    end

    // The pipeline never stalls, so a grant is an accept; nothing is
    // accepted while reset is held
    assign req_ready = grant & {2{rst_n}};
    assign accept    = |grant;
    assign sel       = grant[PORT_DBG];

    // Capture the accepted request into the command stage
    always_comb begin
        last_grant_d = last_grant_q;
        cmd_valid_d  = accept;
        cmd_d        = cmd_q;
        cmd_addr_d   = cmd_addr_q;
        if (accept) begin
            last_grant_d = sel;
            cmd_addr_d   = addr_arr[sel];
            cmd_d.owner  = sel;
            cmd_d.we     = req_we[sel];
            cmd_d.size   = size_arr[sel];
            cmd_d.sgn    = req_signed[sel];
            cmd_d.wdata  = wdata_arr[sel];
            cmd_d.err    = size_err(size_arr[sel], addr_arr[sel][1:0]);
        end
    end

    // Memory controls come straight from the command stage; errored
    // commands never touch the memory
    assign issue_ok    = cmd_valid_q & ~cmd_q.err;
    assign mem_we      = issue_ok & cmd_q.we;
    assign mem_re      = issue_ok & ~cmd_q.we;
    assign mem_special = mem_we & (cmd_q.size != SZ_WORD);
    assign mem_borh    = mem_special & (cmd_q.size == SZ_HALF);
    assign mem_addr    = cmd_addr_q[AW+1:2];
    assign mem_lasttwo = cmd_addr_q[1:0];
    assign mem_wdata   = cmd_q.wdata;

    dmem_load_align u_align (
        .word_i    (mem_rdata),
        .lasttwo_i (cmd_addr_q[1:0]),
        .size_i    (cmd_q.size),
        .sgn_i     (cmd_q.sgn),
        .data_o    (load_data)
    );

    // Build the response for the command issuing this cycle
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        if (cmd_valid_q) begin
            rsp_valid_d[cmd_q.owner] = 1'b1;
            rsp_err_d                = cmd_q.err;
            if (!cmd_q.we && !cmd_q.err) rsp_rdata_d = load_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // State registers; reset drops any in-flight command and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= '0;
            cmd_addr_q   <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0;
        end else begin
            last_grant_q <= last_grant_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            cmd_addr_q   <= cmd_addr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a behavioural word memory
// driven by the DUT's controls, a byte-array reference model updated at
// accept time, and a response scoreboard checked on the falling edge.
module tb_dmem_port_arbiter;

    localparam int AW = 7;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } tb_req_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_we = 2'b00;
    logic [3:0]  req_size = 4'h0;
    logic [1:0]  req_signed = 2'b00;
    logic [17:0] req_addr = 18'h0;
    logic [63:0] req_wdata = 64'h0;

    logic [1:0]    req_ready, rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re, mem_special, mem_borh;
    logic [1:0]    mem_lasttwo;

    logic [1:0]    fix_req_ready, fix_rsp_valid;
    logic          fix_rsp_err;
    logic [31:0]   fix_rsp_rdata, fix_mem_wdata;
    logic [AW-1:0] fix_mem_addr;
    logic          fix_mem_we, fix_mem_re, fix_mem_special, fix_mem_borh;
    logic [1:0]    fix_mem_lasttwo;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle_cnt = 0;
    int fix_cnt0 = 0;
    int fix_cnt1 = 0;
    logic exp_last = 1'b1;
    sb_t  sb_q[$];
    sb_t  mon_e;
    logic [1:0] mon_v;

    logic [31:0] tb_mem [0:127];
    logic [7:0]  ref_mem [0:511];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_re(mem_re), .mem_special(mem_special), .mem_borh(mem_borh),
        .mem_lasttwo(mem_lasttwo), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_port_arbiter #(.AW(AW), .RR_EN(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(fix_req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(fix_rsp_valid), .rsp_err(fix_rsp_err),
        .rsp_rdata(fix_rsp_rdata), .mem_addr(fix_mem_addr), .mem_we(fix_mem_we),
        .mem_re(fix_mem_re), .mem_special(fix_mem_special), .mem_borh(fix_mem_borh),
        .mem_lasttwo(fix_mem_lasttwo), .mem_wdata(fix_mem_wdata), .mem_rdata(32'h0)
    );

    // Behavioural memory: combinational read, lane-masked write on the edge
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            if (!mem_special)
                tb_mem[mem_addr] <= mem_wdata;
            else if (!mem_borh)
                tb_mem[mem_addr][int'(mem_lasttwo)*8 +: 8] <= mem_wdata[7:0];
            else
                tb_mem[mem_addr][int'(mem_lasttwo[1])*16 +: 16] <= mem_wdata[15:0];
        end
    end

    // Cycle counter and response counters of the fixed-priority instance
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        fix_cnt0  <= fix_cnt0 + int'(fix_rsp_valid[0]);
        fix_cnt1  <= fix_cnt1 + int'(fix_rsp_valid[1]);
    end

    // Response monitor: the head of the scoreboard must appear exactly on
    // its due cycle, and nothing may appear otherwise
    always @(negedge clk) begin
        if (sb_q.size() != 0 && sb_q[0].due == cycle_cnt) begin
            mon_e = sb_q.pop_front();
            mon_v = (mon_e.port == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (rsp_valid !== mon_v || rsp_err !== mon_e.err || rsp_rdata !== mon_e.rdata) begin
                n_bad++;
                $display("FAIL response: got valid=%b err=%b rdata=%h expected valid=%b err=%b rdata=%h",
                         rsp_valid, rsp_err, rsp_rdata, mon_v, mon_e.err, mon_e.rdata);
            end else begin
                $display("rsp port=%0d err=%0b rdata=%h", mon_e.port, rsp_err, rsp_rdata);
            end
        end else if (rsp_valid !== 2'b00) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got valid=%b expected 00", rsp_valid);
        end
    end

    function automatic tb_req_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [8:0] addr, input logic [31:0] wdata);
        tb_req_t r;
        r.we = we; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // Drive one cycle of requests, check the grant, and record the expected
    // response of whichever request is accepted
    task automatic drive_cycle(input logic [1:0] v, input tb_req_t r0, input tb_req_t r1);
        logic [1:0] g;
        tb_req_t    r;
        sb_t        e;
        int         a;
        logic [15:0] h;
        @(negedge clk);
        req_valid  = v;
        req_we     = {r1.we, r0.we};
        req_size   = {r1.size, r0.size};
        req_signed = {r1.sgn, r0.sgn};
        req_addr   = {r1.addr, r0.addr};
        req_wdata  = {r1.wdata, r0.wdata};
        #1;
        if (v == 2'b11) g = exp_last ? 2'b01 : 2'b10;
        else            g = v;
        n_cmp++;
        if (req_ready !== g) begin
            n_bad++;
            $display("FAIL req_ready: got %b expected %b", req_ready, g);
        end
        if (g != 2'b00) begin
            r = g[1] ? r1 : r0;
            exp_last = g[1];
            a = int'(r.addr);
            e.port  = g[1] ? 1 : 0;
            e.due   = cycle_cnt + 2;
            e.rdata = 32'h0;
            e.err   = (r.size == 2'b11) || (r.size == 2'b01 && r.addr[0]) ||
                      (r.size == 2'b10 && r.addr[1:0] != 2'b00);
            if (!e.err) begin
                if (r.we) begin
                    ref_mem[a] = r.wdata[7:0];
                    if (r.size != 2'b00) ref_mem[a+1] = r.wdata[15:8];
                    if (r.size == 2'b10) begin
                        ref_mem[a+2] = r.wdata[23:16];
                        ref_mem[a+3] = r.wdata[31:24];
                    end
                end else if (r.size == 2'b00) begin
                    e.rdata = {{24{r.sgn & ref_mem[a][7]}}, ref_mem[a]};
                end else if (r.size == 2'b01) begin
                    h = {ref_mem[a+1], ref_mem[a]};
                    e.rdata = {{16{r.sgn & h[15]}}, h};
                end else begin
                    e.rdata = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
                end
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 2'b00;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        sb_q.delete();
        exp_last = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 2'b11;
        req_size  = 4'b1010;
        #1;
        n_cmp++;
        if ({req_ready, fix_req_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b/%b expected 00/00", req_ready, fix_req_ready);
        end
        n_cmp++;
        if ({mem_we, mem_re, mem_special, mem_borh, mem_lasttwo, mem_addr, mem_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_mem: got we=%b re=%b addr=%h wdata=%h expected all 0",
                     mem_we, mem_re, mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h expected 0", rsp_valid, rsp_err, rsp_rdata);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1'b1;
    endtask

    task automatic test_word_byte();
        drive_cycle(2'b01, mk(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF), mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0));
        idle();
        n_cmp++;
        if ({mem_we, mem_re, mem_special, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 7'd4, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL word_store_issue: got we=%b re=%b special=%b addr=%0d wdata=%h expected 1 0 0 4 deadbeef",
                     mem_we, mem_re, mem_special, mem_addr, mem_wdata);
        end
        idle();
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL word_store_once: got mem_we=%b expected 0", mem_we);
        end
        drive_cycle(2'b01, mk(1'b0, 2'b00, 1'b1, 9'h013, 32'h0), mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0));
        idle();
        n_cmp++;
        if ({mem_we, mem_re, mem_addr, mem_lasttwo} !== {1'b0, 1'b1, 7'd4, 2'b11}) begin
            n_bad++;
            $display("FAIL byte_load_issue: got we=%b re=%b addr=%0d lasttwo=%b expected 0 1 4 11",
                     mem_we, mem_re, mem_addr, mem_lasttwo);
        end
        repeat (3) idle();
    endtask

    task automatic test_half();
        drive_cycle(2'b10, mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0), mk(1'b1, 2'b01, 1'b0, 9'h00A, 32'h00001234));
        idle();
        n_cmp++;
        if ({mem_we, mem_special, mem_borh, mem_lasttwo, mem_addr} !== {1'b1, 1'b1, 1'b1, 2'b10, 7'd2}) begin
            n_bad++;
            $display("FAIL half_store_issue: got we=%b special=%b borh=%b lasttwo=%b addr=%0d expected 1 1 1 10 2",
                     mem_we, mem_special, mem_borh, mem_lasttwo, mem_addr);
        end
        idle();
        drive_cycle(2'b10, mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0), mk(1'b0, 2'b01, 1'b0, 9'h00A, 32'h0));
        repeat (3) idle();
    endtask

    task automatic test_back_to_back();
        tb_req_t nil;
        nil = mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0);
        drive_cycle(2'b01, mk(1'b1, 2'b10, 1'b0, 9'h040, 32'hA5A55A5A), nil);
        drive_cycle(2'b10, nil, mk(1'b0, 2'b10, 1'b0, 9'h040, 32'h0));
        drive_cycle(2'b10, nil, mk(1'b1, 2'b00, 1'b0, 9'h041, 32'h00000080));
        drive_cycle(2'b01, mk(1'b0, 2'b00, 1'b1, 9'h041, 32'h0), nil);
        drive_cycle(2'b01, mk(1'b0, 2'b01, 1'b1, 9'h042, 32'h0), nil);
        drive_cycle(2'b01, mk(1'b0, 2'b00, 1'b0, 9'h043, 32'h0), nil);
        repeat (3) idle();
    endtask

    task automatic test_round_robin();
        tb_req_t rr0 [4];
        tb_req_t rr1 [4];
        int base0, base1;
        rr0[0] = mk(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
        rr0[1] = mk(1'b0, 2'b01, 1'b1, 9'h012, 32'h0);
        rr0[2] = mk(1'b0, 2'b00, 1'b0, 9'h011, 32'h0);
        rr0[3] = mk(1'b0, 2'b10, 1'b0, 9'h040, 32'h0);
        rr1[0] = mk(1'b0, 2'b01, 1'b0, 9'h00A, 32'h0);
        rr1[1] = mk(1'b0, 2'b10, 1'b0, 9'h040, 32'h0);
        rr1[2] = mk(1'b0, 2'b00, 1'b1, 9'h013, 32'h0);
        rr1[3] = mk(1'b0, 2'b01, 1'b1, 9'h042, 32'h0);
        do_reset();
        base0 = fix_cnt0;
        base1 = fix_cnt1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(2'b11, rr0[i], rr1[i]);
            n_cmp++;
            if (fix_req_ready !== 2'b01) begin
                n_bad++;
                $display("FAIL fixed_ready[%0d]: got %b expected 01", i, fix_req_ready);
            end
        end
        repeat (4) idle();
        n_cmp++;
        if ((fix_cnt0 - base0) != 4 || (fix_cnt1 - base1) != 0) begin
            n_bad++;
            $display("FAIL fixed_rsp_count: got p0=%0d p1=%0d expected 4 0", fix_cnt0 - base0, fix_cnt1 - base1);
        end
    endtask

    task automatic test_errors();
        tb_req_t nil;
        nil = mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0);
        drive_cycle(2'b01, mk(1'b0, 2'b10, 1'b0, 9'h005, 32'h0), nil);
        idle();
        n_cmp++;
        if ({mem_we, mem_re} !== 2'b00) begin
            n_bad++;
            $display("FAIL misaligned_issue: got we=%b re=%b expected 0 0", mem_we, mem_re);
        end
        drive_cycle(2'b10, nil, mk(1'b1, 2'b11, 1'b0, 9'h010, 32'h0));
        idle();
        n_cmp++;
        if ({mem_we, mem_re} !== 2'b00) begin
            n_bad++;
            $display("FAIL illegal_size_issue: got we=%b re=%b expected 0 0", mem_we, mem_re);
        end
        drive_cycle(2'b01, mk(1'b1, 2'b01, 1'b0, 9'h011, 32'h0), nil);
        repeat (3) idle();
        n_cmp++;
        if (tb_mem[4] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL error_no_write: got %h expected deadbeef", tb_mem[4]);
        end
    endtask

    task automatic test_reset_mid();
        tb_req_t nil;
        logic [7:0] saved [4];
        nil = mk(1'b0, 2'b00, 1'b0, 9'h0, 32'h0);
        drive_cycle(2'b01, mk(1'b1, 2'b10, 1'b0, 9'h020, 32'h11223344), nil);
        repeat (3) idle();
        for (int i = 0; i < 4; i++) saved[i] = ref_mem[32 + i];
        drive_cycle(2'b01, mk(1'b1, 2'b10, 1'b0, 9'h020, 32'hCAFEF00D), nil);
        idle();
        n_cmp++;
        if (mem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_issue: got mem_we=%b expected 1", mem_we);
        end
        rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 4; i++) ref_mem[32 + i] = saved[i];
        exp_last = 1'b1;
        #1;
        n_cmp++;
        if ({mem_we, mem_re} !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset_drop: got we=%b re=%b expected 0 0", mem_we, mem_re);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) idle();
        n_cmp++;
        if (tb_mem[8] !== 32'h11223344) begin
            n_bad++;
            $display("FAIL midreset_mem: got %h expected 11223344", tb_mem[8]);
        end
        drive_cycle(2'b10, nil, mk(1'b0, 2'b10, 1'b0, 9'h020, 32'h0));
        repeat (3) idle();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_word_byte();
        test_half();
        test_back_to_back();
        test_round_robin();
        test_errors();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_rsp: got %0d outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
